// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider slice.
// State encodings are plain localparam constants so older code that
// compares raw 2-bit values against the state keeps working.
package div_pkg;

    // Operand/result width used across the EX stage.
    localparam int DIV_N_REG = 32;

    // Iteration counter width; must hold values 0..DIV_N_REG.
    localparam int DIV_N_CNT = 6;

    // Number of restoring iterations needed for a full-width divide.
    localparam int DIV_ITER = DIV_N_REG;

    // Sequencer state type and encodings.
    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_IDLE    = 2'd0;
    localparam div_state_t DIV_BUSY    = 2'd1;
    localparam div_state_t DIV_DIVZERO = 2'd2;
    localparam div_state_t DIV_DONE    = 2'd3;

endpackage : div_pkg

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// The partial remainder and quotient are treated as one long shift
// register: the quotient MSB moves into the remainder, a trial
// subtraction is made, and the new quotient bit enters at the bottom.
module div_step
    import div_pkg::*;
#(
    parameter int N_REG = DIV_N_REG
) (
    input  logic [N_REG:0]   rem_in,
    input  logic [N_REG-1:0] quo_in,
    input  logic [N_REG-1:0] divisor,
    output logic [N_REG:0]   rem_out,
    output logic [N_REG-1:0] quo_out
);

    logic [N_REG+1:0] shifted;
    logic [N_REG+1:0] trial;
    logic             fits;

    // Shift, trial-subtract, and keep the difference only when it did not go negative.
    always_comb begin
        shifted = {rem_in, quo_in[N_REG-1]};
        trial   = shifted - {2'b00, divisor};
        fits    = ~trial[N_REG+1];
        rem_out = fits ? trial[N_REG:0] : shifted[N_REG:0];
        quo_out = {quo_in[N_REG-2:0], fits};
    end

endmodule : div_step

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider shared by DIV/DIVU in EX.
// Signed divides run on operand magnitudes; the signs are latched at
// start and applied to the results in the final iteration. Results are
// only published on the transition into DONE, and an annul in DONE
// rolls them back so a cancelled instruction never leaves a trace.
module div_seq
    import div_pkg::*;
#(
    parameter int N_REG = DIV_N_REG,
    parameter int N_CNT = DIV_N_CNT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [N_REG-1:0] i_dividend,
    input  logic [N_REG-1:0] i_divisor,
    input  logic             i_annul,
    output logic             o_ready,
    output logic             o_done,
    output logic [N_REG-1:0] o_quotient,
    output logic [N_REG-1:0] o_remainder
);

    div_state_t       state;
    div_state_t       state_next;

    logic [N_CNT-1:0] cnt;
    logic             neg_q;
    logic             neg_r;
    logic [N_REG-1:0] divisor_r;
    logic [N_REG:0]   rem_r;
    logic [N_REG-1:0] quo_r;

    logic [N_REG-1:0] q_reg;
    logic [N_REG-1:0] r_reg;
    logic [N_REG-1:0] q_prev;
    logic [N_REG-1:0] r_prev;

    logic [N_REG-1:0] dividend_mag;
    logic [N_REG-1:0] divisor_mag;
    logic [N_REG:0]   step_rem;
    logic [N_REG-1:0] step_quo;
    logic [N_REG-1:0] final_q;
    logic [N_REG-1:0] final_r;

    logic             accept;
    logic             last_iter;
    logic             zero_finish;
    logic             done_annul;

    // Single shared iteration; the FSM feeds it the registered working state.
    div_step #(
        .N_REG (N_REG)
    ) u_step (
        .rem_in  (rem_r),
        .quo_in  (quo_r),
        .divisor (divisor_r),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Operand magnitudes at capture time and sign-corrected final results.
    always_comb begin
        dividend_mag = i_dividend;
        divisor_mag  = i_divisor;
        if (i_signed && i_dividend[N_REG-1]) begin
            dividend_mag = ~i_dividend + N_REG'(1);
        end
        if (i_signed && i_divisor[N_REG-1]) begin
            divisor_mag = ~i_divisor + N_REG'(1);
        end
        final_q = neg_q ? (~step_quo + N_REG'(1)) : step_quo;
        final_r = neg_r ? (~step_rem[N_REG-1:0] + N_REG'(1)) : step_rem[N_REG-1:0];
    end

    // Event decode shared by the state, datapath and result registers.
    always_comb begin
        accept      = (state == DIV_IDLE) && i_start && !i_annul;
        last_iter   = (state == DIV_BUSY) && !i_annul && (cnt == N_CNT'(N_REG - 1));
        zero_finish = (state == DIV_DIVZERO) && !i_annul;
        done_annul  = (state == DIV_DONE) && i_annul;
    end

    // Next-state logic for the divide sequencer.
    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: begin
                if (accept) begin
                    state_next = (i_divisor != '0) ? DIV_BUSY : DIV_DIVZERO;
                end
            end
            DIV_BUSY: begin
                if (i_annul) begin
                    state_next = DIV_IDLE;
                end else if (last_iter) begin
                    state_next = DIV_DONE;
                end
            end
            DIV_DIVZERO: begin
                state_next = i_annul ? DIV_IDLE : DIV_DONE;
            end
            DIV_DONE: begin
                state_next = DIV_IDLE;
            end
            default: begin
                state_next = DIV_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Working registers: capture operands on accept, then iterate once per BUSY cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            divisor_r <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
        end else if (accept) begin
            cnt       <= '0;
            neg_q     <= i_signed & (i_dividend[N_REG-1] ^ i_divisor[N_REG-1]);
            neg_r     <= i_signed & i_dividend[N_REG-1];
            divisor_r <= divisor_mag;
            rem_r     <= '0;
            quo_r     <= dividend_mag;
        end else if ((state == DIV_BUSY) && !i_annul) begin
            cnt   <= cnt + N_CNT'(1);
            rem_r <= step_rem;
            quo_r <= step_quo;
        end
    end

    // Published results: written on entry to DONE, restored if DONE is annulled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_reg  <= '0;
            r_reg  <= '0;
            q_prev <= '0;
            r_prev <= '0;
        end else if (last_iter) begin
            q_prev <= q_reg;
            r_prev <= r_reg;
            q_reg  <= final_q;
            r_reg  <= final_r;
        end else if (zero_finish) begin
            q_prev <= q_reg;
            r_prev <= r_reg;
            q_reg  <= '0;
            r_reg  <= '0;
        end else if (done_annul) begin
            q_reg <= q_prev;
            r_reg <= r_prev;
        end
    end

    // Status and result outputs; an annul in DONE hides the fresh result immediately.
    always_comb begin
        o_ready     = (state == DIV_IDLE);
        o_done      = (state == DIV_DONE) && !i_annul;
        o_quotient  = done_annul ? q_prev : q_reg;
        o_remainder = done_annul ? r_prev : r_reg;
    end

endmodule : div_seq

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases, annul and
// reset scenarios, and a randomized run against an arithmetic model.
module tb_div_seq;

    localparam int N = 32;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic         i_signed;
    logic [N-1:0] i_dividend;
    logic [N-1:0] i_divisor;
    logic         i_annul;
    logic         o_ready;
    logic         o_done;
    logic [N-1:0] o_quotient;
    logic [N-1:0] o_remainder;

    int           n_checks   = 0;
    int           n_fails    = 0;
    int           done_count = 0;
    logic [31:0]  prev_q;
    logic [31:0]  prev_r;

    div_seq #(
        .N_REG (32),
        .N_CNT (6)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_signed    (i_signed),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .i_annul     (i_annul),
        .o_ready     (o_ready),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder)
    );

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    // Count result pulses on the falling edge, well away from input changes.
    always @(negedge i_clk) begin
        if (o_done === 1'b1) begin
            done_count++;
        end
    end

    // Hard stop in case the sequence itself hangs.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference divide: plain integer arithmetic in 64 bits so the signed overflow case wraps naturally.
    function automatic void modelDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endfunction

    // Present one start request in the current cycle, then scramble operands after capture.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        i_signed   = sgn;
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
        i_dividend = $urandom;
        i_divisor  = $urandom;
        i_signed   = 1'($urandom);
    endtask

    task automatic runDivide(input string tag, input logic sgn, input logic [31:0] a,
                             input logic [31:0] b, input bit hold_start);
        logic [31:0] eq;
        logic [31:0] er;
        int          cyc;
        int          want_cyc;
        int          dc0;
        modelDiv(sgn, a, b, eq, er);
        want_cyc = (b == 32'd0) ? 2 : 33;
        dc0      = done_count;
        applyStimulus(sgn, a, b);
        cyc = 1;
        checkOutput({tag, "/ready_low"}, 32'(o_ready), 32'd0);
        if (hold_start) begin
            i_start = 1'b1;
        end
        while (!o_done && cyc < 40) begin
            tick();
            cyc++;
        end
        i_start = 1'b0;
        checkOutput({tag, "/done_seen"}, 32'(o_done), 32'd1);
        checkOutput({tag, "/done_cycle"}, 32'(cyc), 32'(want_cyc));
        checkOutput({tag, "/ready_at_done"}, 32'(o_ready), 32'd0);
        checkOutput({tag, "/quotient"}, o_quotient, eq);
        checkOutput({tag, "/remainder"}, o_remainder, er);
        tick();
        checkOutput({tag, "/ready_after"}, 32'(o_ready), 32'd1);
        checkOutput({tag, "/done_pulse"}, 32'(o_done), 32'd0);
        tick();
        checkOutput({tag, "/done_count"}, 32'(done_count - dc0), 32'd1);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          dc0;

        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_signed   = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        i_annul    = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("reset/ready", 32'(o_ready), 32'd1);
        checkOutput("reset/done", 32'(o_done), 32'd0);
        checkOutput("reset/quotient", o_quotient, 32'd0);
        checkOutput("reset/remainder", o_remainder, 32'd0);
        prev_q = 32'd0;
        prev_r = 32'd0;

        $display("[TB] directed divides");
        runDivide("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        runDivide("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        checkOutput("div_m7_2/q_const", o_quotient, 32'hFFFF_FFFD);
        checkOutput("div_m7_2/r_const", o_remainder, 32'hFFFF_FFFF);
        runDivide("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        checkOutput("div_7_m2/r_const", o_remainder, 32'd1);
        runDivide("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        checkOutput("div_ovf/q_const", o_quotient, 32'h8000_0000);
        runDivide("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        runDivide("divu_by_zero", 1'b0, 32'd1234, 32'd0, 1'b0);
        runDivide("divu_refill", 1'b0, 32'd99, 32'd10, 1'b0);
        runDivide("div_by_zero", 1'b1, 32'hFFFF_FF00, 32'd0, 1'b0);
        runDivide("divu_small_big", 1'b0, 32'd5, 32'd9, 1'b0);

        $display("[TB] start held during busy and done");
        runDivide("start_held", 1'b0, 32'd1000, 32'd33, 1'b1);

        $display("[TB] start with annul in idle");
        dc0        = done_count;
        i_dividend = 32'd50;
        i_divisor  = 32'd5;
        i_start    = 1'b1;
        i_annul    = 1'b1;
        tick();
        i_start = 1'b0;
        i_annul = 1'b0;
        checkOutput("start_annul/ready", 32'(o_ready), 32'd1);
        repeat (40) tick();
        checkOutput("start_annul/no_done", 32'(done_count - dc0), 32'd0);

        $display("[TB] annul during busy");
        dc0 = done_count;
        applyStimulus(1'b0, 32'd777, 32'd3);
        repeat (9) tick();
        i_annul = 1'b1;
        tick();
        i_annul = 1'b0;
        checkOutput("annul_busy/ready", 32'(o_ready), 32'd1);
        checkOutput("annul_busy/q_kept", o_quotient, prev_q);
        checkOutput("annul_busy/r_kept", o_remainder, prev_r);
        repeat (40) tick();
        checkOutput("annul_busy/no_done", 32'(done_count - dc0), 32'd0);
        checkOutput("annul_busy/q_still", o_quotient, prev_q);

        $display("[TB] annul during busy then back-to-back start");
        applyStimulus(1'b1, 32'hFFFF_0000, 32'd17);
        repeat (9) tick();
        i_annul = 1'b1;
        tick();
        i_annul = 1'b0;
        checkOutput("annul_b2b/ready", 32'(o_ready), 32'd1);
        runDivide("annul_b2b", 1'b1, 32'd12345, 32'hFFFF_FFF6, 1'b0);

        $display("[TB] annul in done");
        dc0 = done_count;
        applyStimulus(1'b0, 32'd4096, 32'd3);
        repeat (32) tick();
        i_annul = 1'b1;
        #1;
        checkOutput("annul_done/done", 32'(o_done), 32'd0);
        checkOutput("annul_done/q_kept", o_quotient, prev_q);
        checkOutput("annul_done/r_kept", o_remainder, prev_r);
        tick();
        i_annul = 1'b0;
        checkOutput("annul_done/ready", 32'(o_ready), 32'd1);
        checkOutput("annul_done/q_after", o_quotient, prev_q);
        checkOutput("annul_done/r_after", o_remainder, prev_r);
        tick();
        checkOutput("annul_done/no_done", 32'(done_count - dc0), 32'd0);

        $display("[TB] randomized divides");
        for (int k = 0; k < 24; k++) begin
            ra = $urandom;
            rs = 1'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            runDivide("random", rs, ra, rb, 1'b0);
        end

        $display("[TB] reset mid-busy");
        runDivide("pre_reset", 1'b0, 32'd90, 32'd4, 1'b0);
        applyStimulus(1'b0, 32'd500, 32'd7);
        repeat (4) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checkOutput("reset_busy/ready", 32'(o_ready), 32'd1);
        checkOutput("reset_busy/done", 32'(o_done), 32'd0);
        checkOutput("reset_busy/quotient", o_quotient, 32'd0);
        checkOutput("reset_busy/remainder", o_remainder, 32'd0);
        runDivide("post_reset", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_div_seq
